// File: rtl/emotion_arbiter.sv
// emotion_arbiter
// Arbitrates three emotion sources (camera classifier, wearable, manual panel)
// into one committed 3-bit emotion_code for the desk mood FSM. A source is
// granted round-robin and must hold the same code for STABLE_CYC cycles before
// it is committed. A committed code is held for DWELL_CYC cycles. After that,
// TIMEOUT_CYC cycles with no request revert the output to IDLE (000).
//
// Optional feature: define DESK_OVERRIDE_EN to add a desk override path.
// override_valid commits override_code directly, skipping qualification.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   src_valid[2:0]    per-source request
//   src_code[8:0]     source i code in bits [3i+2:3i]
//   override_valid    (DESK_OVERRIDE_EN only) force commit of override_code
//   override_code     (DESK_OVERRIDE_EN only)
//   src_ack[2:0]      one-cycle grant pulse, registered
//   emotion_code[2:0] committed code
//   code_change       one-cycle pulse when emotion_code changes value
//   active_src[1:0]   source of the committed code, 3 = none/timeout/override
//   busy              high while qualifying or holding
module emotion_arbiter #(
    parameter int STABLE_CYC  = 4,
    parameter int DWELL_CYC   = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] src_valid,
    input  logic [8:0] src_code,
`ifdef DESK_OVERRIDE_EN
    input  logic       override_valid,
    input  logic [2:0] override_code,
`endif
    output logic [2:0] src_ack,
    output logic [2:0] emotion_code,
    output logic       code_change,
    output logic [1:0] active_src,
    output logic       busy
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int DW = $clog2(DWELL_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, QUAL, HOLD, MON} state_t;

    state_t         state;
    logic [1:0]     rr_ptr;
    logic [1:0]     cand_src;
    logic [2:0]     cand_raw;   // code as captured; the match test uses this
    logic [SW-1:0]  stab_cnt;
    logic [DW-1:0]  dwell_cnt;
    logic [TW-1:0]  idle_cnt;

    function automatic logic [2:0] code_of(input logic [8:0] c, input logic [1:0] s);
        case (s)
            2'd0:    code_of = c[2:0];
            2'd1:    code_of = c[5:3];
            default: code_of = c[8:6];
        endcase
    endfunction

    function automatic logic valid_of(input logic [2:0] v, input logic [1:0] s);
        case (s)
            2'd0:    valid_of = v[0];
            2'd1:    valid_of = v[1];
            default: valid_of = v[2];
        endcase
    endfunction

    // Codes 100..111 are not defined emotions; they collapse to IDLE.
    function automatic logic [2:0] norm(input logic [2:0] c);
        norm = c[2] ? 3'd0 : c;
    endfunction

    // Round-robin winner: first requester at or above rr_ptr, wrapping 2->0.
    // The loop runs from far to near so the nearest requester is the last write.
    logic       win_hit;
    logic [1:0] win_src;
    always_comb begin
        win_hit = 1'b0;
        win_src = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            logic [2:0] idx;
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (src_valid[idx]) begin
                win_hit = 1'b1;
                win_src = idx[1:0];
            end
        end
    end

    logic match;
    assign match = valid_of(src_valid, cand_src) && (code_of(src_code, cand_src) == cand_raw);

    assign busy = (state == QUAL) || (state == HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= 2'd0;
            cand_src     <= 2'd0;
            cand_raw     <= 3'd0;
            stab_cnt     <= '0;
            dwell_cnt    <= '0;
            idle_cnt     <= '0;
            src_ack      <= 3'd0;
            emotion_code <= 3'd0;
            code_change  <= 1'b0;
            active_src   <= 2'd3;
        end else begin
            src_ack     <= 3'd0;
            code_change <= 1'b0;
`ifdef DESK_OVERRIDE_EN
            if (override_valid) begin
                emotion_code <= norm(override_code);
                active_src   <= 2'd3;
                code_change  <= (norm(override_code) != emotion_code);
                dwell_cnt    <= '0;
                state        <= HOLD;
            end else
`endif
            begin
                case (state)
                    IDLE, MON: begin
                        if (win_hit) begin
                            // Capture wins over a coinciding timeout.
                            cand_src <= win_src;
                            cand_raw <= code_of(src_code, win_src);
                            stab_cnt <= SW'(1);
                            src_ack  <= 3'd1 << win_src;
                            state    <= QUAL;
                        end else if (state == MON) begin
                            if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                                code_change  <= (emotion_code != 3'd0);
                                emotion_code <= 3'd0;
                                active_src   <= 2'd3;
                                idle_cnt     <= '0;
                                state        <= IDLE;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                    end
                    QUAL: begin
                        if (match) begin
                            if (stab_cnt == SW'(STABLE_CYC - 1)) begin
                                emotion_code <= norm(cand_raw);
                                code_change  <= (norm(cand_raw) != emotion_code);
                                active_src   <= cand_src;
                                rr_ptr       <= (cand_src == 2'd2) ? 2'd0 : cand_src + 2'd1;
                                dwell_cnt    <= '0;
                                state        <= HOLD;
                            end else begin
                                stab_cnt <= stab_cnt + 1'b1;
                            end
                        end else begin
                            idle_cnt <= '0;
                            state    <= (emotion_code != 3'd0) ? MON : IDLE;
                        end
                    end
                    HOLD: begin
                        if (dwell_cnt == DW'(DWELL_CYC - 1)) begin
                            idle_cnt <= '0;
                            state    <= MON;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_emotion_arbiter.sv
module tb_emotion_arbiter;

    localparam int STABLE  = 4;
    localparam int DWELL   = 16;
    localparam int TIMEOUT = 256;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] src_valid;
    logic [8:0] src_code;
`ifdef DESK_OVERRIDE_EN
    logic       override_valid;
    logic [2:0] override_code;
`endif
    logic [2:0] src_ack;
    logic [2:0] emotion_code;
    logic       code_change;
    logic [1:0] active_src;
    logic       busy;

    int checks = 0;
    int errors = 0;

    emotion_arbiter #(.STABLE_CYC(STABLE), .DWELL_CYC(DWELL), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_code(src_code),
`ifdef DESK_OVERRIDE_EN
        .override_valid(override_valid), .override_code(override_code),
`endif
        .src_ack(src_ack), .emotion_code(emotion_code), .code_change(code_change),
        .active_src(active_src), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 qualifying, 2 holding, 3 monitoring.
    int m_ph, m_code, m_src, m_ack, m_chg, m_rr, m_cand, m_raw, m_cnt, m_dwell, m_idle;

    task automatic model_commit(input int raw, input int src);
        int n;
        n = (raw > 3) ? 0 : raw;
        m_chg = (n != m_code);
        m_code = n;
        m_src = src;
        m_dwell = 0;
        m_ph = 2;
    endtask

    task automatic model_edge();
        int v[3];
        int c[3];
        int w;
        for (int i = 0; i < 3; i++) begin
            v[i] = int'(src_valid[i]);
            c[i] = int'(src_code[3*i +: 3]);
        end
        m_ack = 0;
        m_chg = 0;
        if (!reset_n) begin
            m_ph = 0; m_code = 0; m_src = 3; m_rr = 0;
            m_cnt = 0; m_dwell = 0; m_idle = 0;
            return;
        end
`ifdef DESK_OVERRIDE_EN
        if (override_valid) begin
            model_commit(int'(override_code), 3);
            return;
        end
`endif
        if (m_ph == 0 || m_ph == 3) begin
            w = -1;
            for (int k = 0; k < 3; k++)
                if (w < 0 && v[(m_rr + k) % 3] != 0) w = (m_rr + k) % 3;
            if (w >= 0) begin
                m_cand = w; m_raw = c[w]; m_cnt = 1; m_ack = 1 << w; m_ph = 1;
            end else if (m_ph == 3) begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_chg = (m_code != 0); m_code = 0; m_src = 3; m_ph = 0;
                end
            end
        end else if (m_ph == 1) begin
            if (v[m_cand] != 0 && c[m_cand] == m_raw) begin
                m_cnt++;
                if (m_cnt >= STABLE) begin
                    model_commit(m_raw, m_cand);
                    m_rr = (m_cand + 1) % 3;
                end
            end else begin
                m_ph = (m_code != 0) ? 3 : 0;
                m_idle = 0;
            end
        end else begin
            m_dwell++;
            if (m_dwell >= DWELL) begin
                m_ph = 3; m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the current inputs, then compare after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("emotion_code", 8'(emotion_code), 8'(m_code));
        chk("active_src",   8'(active_src),   8'(m_src));
        chk("src_ack",      8'(src_ack),      8'(m_ack));
        chk("code_change",  8'(code_change),  8'(m_chg));
        chk("busy",         8'(busy),         8'((m_ph == 1 || m_ph == 2) ? 1 : 0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src_valid = 3'b000;
        steps(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        src_valid = 3'b111;
        src_code = {3'd3, 3'd2, 3'd1};
`ifdef DESK_OVERRIDE_EN
        override_valid = 1'b0;
        override_code = 3'd0;
`endif
        m_ph = 0; m_code = 0; m_src = 3; m_rr = 0; m_cand = 0; m_raw = 0;
        m_cnt = 0; m_dwell = 0; m_idle = 0; m_ack = 0; m_chg = 0;

        // Reset with every source requesting.
        steps(2);
        chk("rst_code", 8'(emotion_code), 8'd0);
        chk("rst_src",  8'(active_src),   8'd3);
        chk("rst_ack",  8'(src_ack),      8'd0);
        chk("rst_busy", 8'(busy),         8'd0);
        reset_n = 1'b1;
        step();
        chk("rst_first_ack", 8'(src_ack), 8'b001);

        // Single source, latency.
        do_reset();
        src_valid = 3'b010; src_code = {3'd0, 3'd2, 3'd0};
        step();
        chk("single_ack", 8'(src_ack), 8'b010);
        steps(2);
        chk("single_early", 8'(emotion_code), 8'd0);
        step();
        chk("single_code", 8'(emotion_code), 8'd2);
        chk("single_chg",  8'(code_change),  8'd1);
        chk("single_src",  8'(active_src),   8'd1);
        chk("single_busy", 8'(busy),         8'd1);
        steps(DWELL - 1);
        chk("single_hold_busy", 8'(busy), 8'd1);

        // Glitch rejection.
        do_reset();
        src_valid = 3'b001; src_code = {3'd0, 3'd0, 3'd1};
        steps(2);
        src_valid = 3'b000;
        steps(4);
        chk("glitch_code", 8'(emotion_code), 8'd0);
        chk("glitch_busy", 8'(busy),         8'd0);

        // Round-robin: src0 first, then src2.
        do_reset();
        src_valid = 3'b101; src_code = {3'd3, 3'd0, 3'd1};
        steps(STABLE);
        chk("rr_first_code", 8'(emotion_code), 8'd1);
        chk("rr_first_src",  8'(active_src),   8'd0);
        steps(DWELL);
        step();
        chk("rr_second_ack", 8'(src_ack), 8'b100);
        steps(STABLE - 1);
        chk("rr_second_code", 8'(emotion_code), 8'd3);
        chk("rr_second_src",  8'(active_src),   8'd2);

        // Dwell: a changed code waits out the hold.
        do_reset();
        src_valid = 3'b001; src_code = {3'd0, 3'd0, 3'd1};
        steps(STABLE);
        src_code = {3'd0, 3'd0, 3'd3};
        steps(DWELL);
        chk("dwell_held", 8'(emotion_code), 8'd1);
        step();
        chk("dwell_ack", 8'(src_ack), 8'b001);
        steps(STABLE - 1);
        chk("dwell_code", 8'(emotion_code), 8'd3);

        // Normalisation: 101 commits as 000, no change pulse.
        do_reset();
        src_valid = 3'b100; src_code = {3'd5, 3'd0, 3'd0};
        steps(STABLE);
        chk("norm_code", 8'(emotion_code), 8'd0);
        chk("norm_chg",  8'(code_change),  8'd0);
        chk("norm_src",  8'(active_src),   8'd2);

        // Timeout back to IDLE.
        do_reset();
        src_valid = 3'b010; src_code = {3'd0, 3'd2, 3'd0};
        steps(STABLE);
        src_valid = 3'b000;
        steps(DWELL + TIMEOUT - 1);
        chk("to_before", 8'(emotion_code), 8'd2);
        step();
        chk("to_code", 8'(emotion_code), 8'd0);
        chk("to_chg",  8'(code_change),  8'd1);
        chk("to_src",  8'(active_src),   8'd3);

`ifdef DESK_OVERRIDE_EN
        // Override mid-qualification.
        do_reset();
        src_valid = 3'b010; src_code = {3'd0, 3'd2, 3'd0};
        step();
        override_valid = 1'b1; override_code = 3'd3;
        step();
        chk("ovr_code", 8'(emotion_code), 8'd3);
        chk("ovr_src",  8'(active_src),   8'd3);
        chk("ovr_ack",  8'(src_ack),      8'd0);
        override_valid = 1'b0;
`endif

        // Randomised traffic with sticky inputs so codes can qualify.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) src_valid = 3'($urandom_range(0, 7));
            for (int s = 0; s < 3; s++)
                if ($urandom_range(0, 5) == 0) src_code[3*s +: 3] = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 299) != 0);
`ifdef DESK_OVERRIDE_EN
            override_valid = ($urandom_range(0, 99) == 0);
            override_code = 3'($urandom_range(0, 7));
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
